// File: rtl/link_align_ctrl.sv
// link_align_ctrl: time-shared word-alignment sequencer for an array of
// deserialized input links. Visits links 0..NLINK-1 in turn, slipping the
// selected deserializer until TRAIN_WORD is seen MATCH_CNT times in a row,
// and records a per-link locked/failed result.
//
// Optional build macro: LINK_ALIGN_CTRL_POLARITY_DETECT_EN
//   When defined, the bit-inverted training word also counts as a match and a
//   lock achieved on inverted words raises polarity[] for that link.
//   When undefined, polarity[] stays 0.
module link_align_ctrl #(
  parameter int unsigned          NLINK      = 1,
  parameter int unsigned          WORD_W     = 8,
  parameter logic [WORD_W-1:0]    TRAIN_WORD = WORD_W'(8'hAC),
  parameter int unsigned          MATCH_CNT  = 4,
  parameter int unsigned          SETTLE_CYC = 2,
  localparam int unsigned         IDX_W      = (NLINK > 1) ? $clog2(NLINK) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NLINK*WORD_W-1:0]   data_in,
  output logic [NLINK-1:0]          bitslip,
  output logic [IDX_W-1:0]          cur_link,
  output logic                      busy,
  output logic                      done,
  output logic [NLINK-1:0]          locked,
  output logic [NLINK-1:0]          failed,
  output logic [NLINK-1:0]          polarity
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SLIP_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [IDX_W-1:0]  LAST_LINK  = IDX_W'(NLINK - 1);
  localparam logic [SLIP_W-1:0] LAST_SLIP  = SLIP_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  MATCH_END  = CNT_W'(MATCH_CNT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CHECK  = 3'd2,
    SLIP   = 3'd3,
    NEXT   = 3'd4
  } state_t;

  state_t              state_q,      state_d;
  logic [IDX_W-1:0]    cur_link_q,   cur_link_d;
  logic [SLIP_W-1:0]   slip_cnt_q,   slip_cnt_d;
  logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0]    match_cnt_q,  match_cnt_d;
  logic                inv_q,        inv_d;
  logic [NLINK-1:0]    locked_q,     locked_d;
  logic [NLINK-1:0]    failed_q,     failed_d;
  logic [NLINK-1:0]    polarity_q,   polarity_d;
  logic [NLINK-1:0]    bitslip_q,    bitslip_d;
  logic                done_q,       done_d;
  logic                busy_q,       busy_d;

  logic [WORD_W-1:0]   cur_word;
  logic                is_true;
  logic                is_inv;
  logic                same_type;
  logic [CNT_W-1:0]    match_next;

  // Select the word of the link currently being scanned
  always_comb begin
    cur_word = '0;
    for (int i = 0; i < int'(NLINK); i++) begin
      if (IDX_W'(i) == cur_link_q) begin
        cur_word = data_in[i*WORD_W +: WORD_W];
      end
    end
  end

  // Classify the selected word and compute the running match count
  always_comb begin
    is_true = (cur_word == TRAIN_WORD);
`ifdef LINK_ALIGN_CTRL_POLARITY_DETECT_EN
    is_inv  = (cur_word == ~TRAIN_WORD);
`else
    is_inv  = 1'b0;
`endif
    // A change between true and inverted matches restarts the run at one
    same_type  = (match_cnt_q == '0) || (inv_q == is_inv);
    match_next = same_type ? (match_cnt_q + CNT_W'(1)) : CNT_W'(1);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cur_link_d   = cur_link_q;
    slip_cnt_d   = slip_cnt_q;
    settle_cnt_d = settle_cnt_q;
    match_cnt_d  = match_cnt_q;
    inv_d        = inv_q;
    locked_d     = locked_q;
    failed_d     = failed_q;
    polarity_d   = polarity_q;
    bitslip_d    = '0;
    done_d       = 1'b0;
    busy_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          locked_d     = '0;
          failed_d     = '0;
          polarity_d   = '0;
          cur_link_d   = '0;
          slip_cnt_d   = '0;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end
      end

      SETTLE: begin
        if (settle_cnt_q == SETTLE_END) begin
          match_cnt_d = '0;
          inv_d       = 1'b0;
          state_d     = CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end

      CHECK: begin
        if (is_true || is_inv) begin
          match_cnt_d = match_next;
          inv_d       = is_inv;
          if (match_next == MATCH_END) begin
            for (int i = 0; i < int'(NLINK); i++) begin
              if (IDX_W'(i) == cur_link_q) begin
                locked_d[i] = 1'b1;
`ifdef LINK_ALIGN_CTRL_POLARITY_DETECT_EN
                polarity_d[i] = is_inv;
`endif
              end
            end
            state_d = NEXT;
          end
        end else if (slip_cnt_q == LAST_SLIP) begin
          // Every alignment position has been tried on this link
          for (int i = 0; i < int'(NLINK); i++) begin
            if (IDX_W'(i) == cur_link_q) begin
              failed_d[i] = 1'b1;
            end
          end
          state_d = NEXT;
        end else begin
          // Any partial run of matches is discarded by the slip
          match_cnt_d = '0;
          state_d     = SLIP;
        end
      end

      SLIP: begin
        slip_cnt_d   = slip_cnt_q + SLIP_W'(1);
        settle_cnt_d = '0;
        state_d      = SETTLE;
      end

      NEXT: begin
        if (cur_link_q == LAST_LINK) begin
          state_d = IDLE;
        end else begin
          cur_link_d   = cur_link_q + IDX_W'(1);
          slip_cnt_d   = '0;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered outputs reflect the state being entered
    for (int i = 0; i < int'(NLINK); i++) begin
      bitslip_d[i] = (state_d == SLIP) && (IDX_W'(i) == cur_link_d);
    end
    done_d = (state_d == NEXT) && (cur_link_d == LAST_LINK);
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_link_q   <= '0;
      slip_cnt_q   <= '0;
      settle_cnt_q <= '0;
      match_cnt_q  <= '0;
      inv_q        <= 1'b0;
      locked_q     <= '0;
      failed_q     <= '0;
      polarity_q   <= '0;
      bitslip_q    <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_link_q   <= cur_link_d;
      slip_cnt_q   <= slip_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      match_cnt_q  <= match_cnt_d;
      inv_q        <= inv_d;
      locked_q     <= locked_d;
      failed_q     <= failed_d;
      polarity_q   <= polarity_d;
      bitslip_q    <= bitslip_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign bitslip  = bitslip_q;
  assign cur_link = cur_link_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign locked   = locked_q;
  assign failed   = failed_q;
  assign polarity = polarity_q;

endmodule

// File: doc/link_align_ctrl.md
Name: link_align_ctrl

Overview:
Shared word-alignment sequencer for the differential input link array. Scans links one at a time, issuing bitslip pulses to the selected link's deserializer until a fixed training word is seen MATCH_CNT consecutive times. Reports per-link lock/fail status. Sits between the buffered/deserialized link words and the per-link ISERDES bitslip inputs; one engine time-shared across all NLINK links.

Parameters:
NLINK, 1, number of links scanned (1..32)
WORD_W, 8, deserialized word width per link
TRAIN_WORD, 8'hAC, expected training word, WORD_W bits
MATCH_CNT, 4, consecutive matches required for lock (1..255)
SETTLE_CYC, 2, wait cycles after link entry or after each slip before comparing (1..255)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a full scan from link 0
data_in  in  NLINK*WORD_W  deserialized words; link i at bits [i*WORD_W +: WORD_W]
bitslip  out  NLINK  one-cycle slip pulse, at most one bit set
cur_link  out  IDX_W  index of link being scanned; IDX_W = max(1, clog2(NLINK))
busy  out  1  high while scan in progress
done  out  1  one-cycle pulse when scan of all links completes
locked  out  NLINK  per-link lock flag
failed  out  NLINK  per-link fail flag
polarity  out  NLINK  per-link inverted-polarity flag (see Optional Feature)

Behaviour:
- Reset: state IDLE; bitslip, cur_link, busy, done, locked, failed, polarity all 0; counters 0. rst mid-scan aborts immediately, same values.
- States: IDLE, SETTLE, CHECK, SLIP, NEXT.
- IDLE: start=1 -> clear locked/failed/polarity, cur_link=0, slip_cnt=0, settle_cnt=0, go SETTLE; busy=1 from next cycle. start while busy ignored.
- SETTLE: settle_cnt increments each cycle; at settle_cnt==SETTLE_CYC-1 -> CHECK, match_cnt=0.
- CHECK: compare data_in word of cur_link to TRAIN_WORD each cycle. Match: match_cnt+1; on reaching MATCH_CNT -> locked[cur_link]=1, go NEXT. Mismatch: if slip_cnt==WORD_W-1 -> failed[cur_link]=1, go NEXT; else -> SLIP.
- SLIP: bitslip[cur_link]=1 for exactly this cycle; slip_cnt+1; settle_cnt=0; go SETTLE.
- Per link: maximum WORD_W-1 slips, i.e. WORD_W alignment positions tried.
- NEXT: if cur_link==NLINK-1 -> done=1 this cycle, busy=0 next cycle, go IDLE; else cur_link+1, slip_cnt=0, settle_cnt=0, go SETTLE.
- Min per-link time, already aligned: SETTLE_CYC + MATCH_CNT + 1 (NEXT) cycles.
- locked and failed mutually exclusive; both hold value until next start or rst.
- Partial match then mismatch: match_cnt discarded, slip taken as normal.
- NLINK=1: cur_link constant 0, IDX_W=1.

Optional Feature:
Macro LINK_ALIGN_CTRL_POLARITY_DETECT_EN.
- Defined: in CHECK, word equal to ~TRAIN_WORD also counts as a match; match_cnt resets if the match type (true/inverted) changes between cycles. Lock on inverted matches sets polarity[cur_link]=1 with locked. Software uses this to correct the INVERT setting of the link buffer.
- Undefined: only TRAIN_WORD matches; polarity tied to 0.

Test Plan:
- NLINK=2, WORD_W=8, MATCH_CNT=4, SETTLE_CYC=2, both links constant 8'hAC; pulse start -> no bitslip; locked=2'b11, failed=0; done 14 cycles after start (2 × 7).
- Link 0 aligned only after 3 slips (model rotates word per slip) -> exactly 3 bitslip[0] pulses, each 1 cycle and separated by at least SETTLE_CYC+1 cycles; locked[0]=1.
- Link 1 constant 8'h00 -> 7 bitslip[1] pulses, then failed[1]=1, locked[1]=0; done pulses once.
- 3 matches then one mismatch on link 0 -> one slip issued, match_cnt restarts; lock only after 4 new consecutive matches.
- rst asserted while in SLIP on link 1 -> next cycle all outputs 0, state IDLE; start while busy has no effect.
- With LINK_ALIGN_CTRL_POLARITY_DETECT_EN defined, link 0 = 8'h53 -> locked[0]=1, polarity[0]=1, no slips; without macro -> 7 slips, then failed[0]=1.
